uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver: configurable baud, data bits, parity and stop bits, with an RX FIFO.
//  Received frames are pushed with per-frame error flags; a valid/ready stream port drains them.
//  Sits between the i_rx pad and the UART bus slave, replacing the fixed 8N1 single-byte receiver.
// PARAMETERS
//  CLK_FREQ    50000000  clk frequency in Hz
//  BAUD_RATE   9600      line rate; CPB = CLK_FREQ/BAUD_RATE (integer, >=4)
//  DATA_BITS   8         data bits per frame, 5..8, sent LSB first
//  PARITY      0         0 = none, 1 = even, 2 = odd
//  STOP_BITS   1         1 or 2
//  FIFO_DEPTH  16        entries, power of 2, >=2
// PORTS
//  clk               in   1   clock
//  reset             in   1   synchronous, active-high reset
//  i_rx              in   1   serial line, async, idle high
//  o_valid           out  1   FIFO head valid
//  i_ready           in   1   consumer accepts head; pop when o_valid && i_ready
//  o_data            out  8   head data, zero-extended above DATA_BITS
//  o_parity_error    out  1   head frame parity mismatch (always 0 when PARITY=0)
//  o_framing_error   out  1   head frame had a 0 in any stop-bit sample
//  o_break           out  1   head frame: data all 0, parity bit 0 (if present), framing error
//  o_count           out  $clog2(FIFO_DEPTH)+1  entries held
//  o_overrun         out  1   sticky: a frame was dropped because the FIFO was full
//  i_clear_overrun   in   1   clears o_overrun
// BEHAVIOUR
//  Reset: o_valid=0, o_count=0, o_overrun=0, FIFO empty, FSM=IDLE, both synchronizer flops=1.
//  o_data and all o_*_error/o_break outputs are 0 whenever o_valid=0.
//  Sync: 2-flop synchronizer on i_rx; the FSM sees only rxs.
//  FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
//  - IDLE: on rxs==0, go to START with cnt=0.
//  - START: at cnt==CPB/2-1 (mid start bit), sample rxs. If 0, go to DATA with cnt=0, idx=0.
//    If 1, it is a false start: go to IDLE with no push.
//  - DATA: at cnt==CPB-1, shift rxs into bit idx. Exit after DATA_BITS samples:
//    to PARITY if PARITY!=0, else to STOP.
//  - PARITY: at cnt==CPB-1, sample p. Even: err = ^data ^ p. Odd: err = ~(^data ^ p).
//  - STOP: at cnt==CPB-1, sample STOP_BITS times; any 0 sample sets the framing error.
//    On the last stop sample the frame is committed to the FIFO at that edge.
//    Next state is IDLE if the last sample was 1, else WAIT_HIGH.
//  - WAIT_HIGH: stay until rxs==1, then go to IDLE. This stops a held break from re-triggering.
//  cnt is 16 bits and resets to 0 at every sample point.
//  Latency: o_valid rises the cycle after the commit edge (empty FIFO).
//  FIFO: first-word fall-through; head stays on o_data until popped.
//  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
//  - Push and pop in the same cycle leave count unchanged.
//  - Push refused when full: frame dropped, o_overrun=1 from the next cycle.
//  - The FIFO is unchanged by a refused push.
//  - Pointers wrap modulo FIFO_DEPTH.
//  - Pop is ignored when empty.
//  o_overrun: i_clear_overrun clears it. If a drop occurs in the same cycle as the clear,
//  the set wins.
//  Reset mid-frame: the partial frame is discarded, and the FIFO and flags return to reset values.
//  o_count is registered and always equals the number of valid entries.
// TESTING (CLK_FREQ=1000000, BAUD_RATE=100000 -> CPB=10; FIFO_DEPTH=4 unless noted)
//  1. 8N1, send 0xA5 ->
//     o_valid rises 1 cycle after mid-stop sample; o_data=0xA5; no errors; o_count=1.
//  2. 7E1 (DATA_BITS=7, PARITY=1): send 0x35 with p=0, then 0x35 with p=1 ->
//     o_data=0x35 both; o_parity_error = 0 then 1.
//  3. 0-glitch of 3 cycles on idle line -> false start: nothing pushed, FSM back to IDLE.
//  4. 2 stop bits, second stop bit driven 0 -> o_framing_error=1.
//     Line held 0 for 30 bit times -> o_break=1 on one entry only (WAIT_HIGH holds).
//  5. i_ready=0, send 5 bytes 0x01..0x05 ->
//     o_count=4, o_overrun=1, entries 0x01..0x04.
//     Drain -> 0x01..0x04 in order.
//     i_clear_overrun -> o_overrun=0.
//  6. Full FIFO, pop coinciding with commit edge -> push accepted; o_count stays 4; no overrun.
//     Reset asserted mid-DATA -> o_valid=0, o_count=0 next cycle.
//     Clean frame after reset is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with configurable data bits,
// parity and stop bits, feeding a first-word fall-through RX FIFO that is
// drained through a valid/ready stream port.
//
// Ports:
//   clk              clock
//   reset            synchronous active-high reset
//   i_rx             asynchronous serial line, idle high
//   o_valid          FIFO head valid
//   i_ready          consumer accepts head (pop when o_valid && i_ready)
//   o_data           head data, zero-extended above DATA_BITS
//   o_parity_error   head frame parity mismatch
//   o_framing_error  head frame saw a 0 in a stop-bit sample
//   o_break          head frame is a line break
//   o_count          number of entries held
//   o_overrun        sticky: a frame was dropped on a full FIFO
//   i_clear_overrun  clears o_overrun
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_rx,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [7:0]                  o_data,
  output logic                        o_parity_error,
  output logic                        o_framing_error,
  output logic                        o_break,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_overrun,
  input  logic                        i_clear_overrun
);

  localparam int unsigned CPB   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } entry_t;

  // ---------------------------------------------------------------------
  // Two-flop synchronizer on the asynchronous line
  // ---------------------------------------------------------------------
  logic rx_meta_q;
  logic rxs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             par_bit_q, par_bit_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             stop_idx_q, stop_idx_d;
  logic             commit_c;
  entry_t           new_entry_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      stop_idx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      stop_idx_q <= stop_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    data_d     = data_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    stop_idx_d = stop_idx_q;
    commit_c   = 1'b0;

    // Entry as it would be committed on this cycle's final stop sample
    new_entry_c.data = data_q;
    new_entry_c.perr = perr_q;
    new_entry_c.ferr = ferr_q | ~rxs_q;
    new_entry_c.brk  = (ferr_q | ~rxs_q) & (data_q == 8'h00) &
                       ((PARITY == 0) | ~par_bit_q);

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d    = S_START;
          data_d     = '0;
          par_bit_d  = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          stop_idx_d = 1'b0;
        end
      end

      // Re-check the line at mid start bit to reject glitches
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d         = '0;
          data_d[idx_q] = rxs_q;
          if (idx_q == IDX_LAST) begin
            state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bit_d = rxs_q;
          perr_d    = (PARITY == 1) ? (^data_q ^ rxs_q) : ~(^data_q ^ rxs_q);
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rxs_q) begin
            ferr_d = 1'b1;
          end
          if (stop_idx_q == STOP_LAST) begin
            commit_c = 1'b1;
            state_d  = rxs_q ? S_IDLE : S_WAIT_HIGH;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end

      // Hold off until the line returns high so a long break yields one entry
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // RX FIFO, first-word fall-through with a registered head
  // ---------------------------------------------------------------------
  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  entry_t           head_q, head_d;
  logic             ovr_q, ovr_d;
  logic             pop_c;
  logic             push_ok_c;
  logic             drop_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage needs no reset: validity is tracked by count and pointers
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= new_entry_c;
    end
  end

  always_comb begin
    pop_c     = valid_q & i_ready;
    push_ok_c = commit_c & ((count_q != CW'(FIFO_DEPTH)) | pop_c);
    drop_c    = commit_c & ~push_ok_c;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);

    // Next head: the entry being written bypasses storage when it lands
    // exactly at the new read pointer; zero when the FIFO goes empty.
    head_d = '0;
    if (valid_d) begin
      if (push_ok_c && (rd_ptr_d == wr_ptr_q)) begin
        head_d = new_entry_c;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end

    // A drop in the same cycle as a clear keeps the flag set
    ovr_d = ovr_q;
    if (i_clear_overrun) begin
      ovr_d = 1'b0;
    end
    if (drop_c) begin
      ovr_d = 1'b1;
    end
  end

  assign o_valid         = valid_q;
  assign o_data          = head_q.data;
  assign o_parity_error  = head_q.perr;
  assign o_framing_error = head_q.ferr;
  assign o_break         = head_q.brk;
  assign o_count         = count_q;
  assign o_overrun       = ovr_q;

endmodule
